// File: rtl/accum_stim_pkg.sv
// accum_stim_pkg: shared types and constants for the accumulator stimulus
// source / response checker.
//   state_t    : checker sequencing states
//   LFSR_TAPS  : Galois feedback mask for the 32-bit stimulus LFSR
//   NO_FAIL    : first_fail_idx value meaning "no mismatch seen"
//   lfsr_step  : one right-shift Galois LFSR step
package accum_stim_pkg;

   typedef enum logic [1:0] {
      RST_DUT = 2'd0,
      RUN     = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [15:0] NO_FAIL   = 16'hFFFF;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/accum_stim_checker_lfsr.sv
// lfsr32_galois: 32-bit right-shift Galois LFSR used as the stimulus source.
//   clock, reset : system clock, synchronous active-high reset
//   seed         : value loaded on reset (must be nonzero)
//   advance      : step the LFSR by one position this cycle
//   state        : current LFSR contents
module lfsr32_galois
   import accum_stim_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] seed,
   input  logic        advance,
   output logic [31:0] state
);

   always_ff @(posedge clock) begin
      if (reset)
         state <= seed;
      else if (advance)
         state <= lfsr_step(state);
   end

endmodule

// File: rtl/accum_stim_checker.sv
// accum_stim_checker: stimulus source and response checker for a registered
// accumulator (acc <= acc + in when en; out = acc).
//
// Sequence: hold the DUT in reset for RESET_CYCLES cycles, drive CYCLES
// beats of LFSR-derived data, spend one DRAIN cycle checking the final beat,
// then park in DONE with the verdict.
//
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   dut_reset       : reset to the DUT
//   dut_in, dut_en  : stimulus data / enable
//   dut_out         : DUT accumulator output
//   done            : set on entering DONE, held until reset
//   pass            : meaningful with done; 1 when no mismatch was seen
//   fail_pulse      : one-cycle pulse per detected mismatch
//   mismatch_count  : saturating mismatch count
//   first_fail_idx  : beat index of the first mismatch (DRAIN = CYCLES),
//                     16'hFFFF if none
//
// The compare happens combinationally each RUN/DRAIN cycle; since every
// output is a register, fail_pulse and the counters show the result of a
// cycle's compare starting on the following cycle.
module accum_stim_checker
   import accum_stim_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               CYCLES       = 256,
   parameter int               RESET_CYCLES = 3,
   parameter logic [31:0]      SEED         = 32'h0000_0001,
   parameter logic [WIDTH-1:0] IN_MASK      = {WIDTH{1'b1}},
   parameter int               EN_RANDOM    = 0
) (
   input  logic             clock,
   input  logic             reset,
   output logic             dut_reset,
   output logic [WIDTH-1:0] dut_in,
   output logic             dut_en,
   input  logic [WIDTH-1:0] dut_out,
   output logic             done,
   output logic             pass,
   output logic             fail_pulse,
   output logic [15:0]      mismatch_count,
   output logic [15:0]      first_fail_idx
);

   localparam logic [15:0] RC_LAST   = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] BEAT_LAST = 16'(CYCLES - 1);
   localparam logic [15:0] DRAIN_IDX = 16'(CYCLES);

   state_t           state;
   logic [15:0]      rcnt;
   logic [15:0]      beat;
   logic [WIDTH-1:0] model_acc;
   logic [31:0]      lfsr;

   logic             last_rst;
   logic             last_beat;
   logic             advance;
   logic             mismatch;
   logic [WIDTH-1:0] stim_in;
   logic             stim_en;
   logic [15:0]      cnt_nxt;
   logic [15:0]      fail_idx;

   // The LFSR always holds the value for the next beat to be driven: it
   // steps whenever that value is loaded into dut_in, and not in DONE.
   lfsr32_galois u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .seed    (SEED),
      .advance (advance),
      .state   (lfsr)
   );

   always_comb begin
      last_rst  = (state == RST_DUT) && (rcnt == RC_LAST);
      last_beat = (beat == BEAT_LAST);
      advance   = last_rst || ((state == RUN) && !last_beat);
      stim_in   = lfsr[WIDTH-1:0] & IN_MASK;
      stim_en   = (EN_RANDOM != 0) ? lfsr[31] : 1'b1;
      // dut_out and model_acc both reflect the inputs of all earlier beats
      mismatch  = ((state == RUN) || (state == DRAIN)) && (dut_out != model_acc);
      cnt_nxt   = (mismatch && (mismatch_count != 16'hFFFF)) ?
                  mismatch_count + 16'd1 : mismatch_count;
      fail_idx  = (state == DRAIN) ? DRAIN_IDX : beat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= RST_DUT;
         dut_reset      <= 1'b1;
         dut_in         <= '0;
         dut_en         <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_pulse     <= 1'b0;
         mismatch_count <= 16'd0;
         first_fail_idx <= NO_FAIL;
         model_acc      <= '0;
         beat           <= 16'd0;
         rcnt           <= 16'd0;
      end else begin
         fail_pulse     <= mismatch;
         mismatch_count <= cnt_nxt;
         if (mismatch && (first_fail_idx == NO_FAIL))
            first_fail_idx <= fail_idx;

         case (state)
            RST_DUT: begin
               dut_reset <= 1'b1;
               dut_en    <= 1'b0;
               dut_in    <= '0;
               model_acc <= '0;
               rcnt      <= rcnt + 16'd1;
               if (last_rst) begin
                  // beat 0 stimulus goes out with the DUT's reset release
                  state     <= RUN;
                  dut_reset <= 1'b0;
                  dut_in    <= stim_in;
                  dut_en    <= stim_en;
               end
            end
            RUN: begin
               // follow exactly what the DUT samples this cycle
               if (dut_en)
                  model_acc <= model_acc + dut_in;
               if (last_beat) begin
                  state  <= DRAIN;
                  dut_in <= '0;
                  dut_en <= 1'b0;
               end else begin
                  beat   <= beat + 16'd1;
                  dut_in <= stim_in;
                  dut_en <= stim_en;
               end
            end
            DRAIN: begin
               state  <= DONE;
               done   <= 1'b1;
               pass   <= (cnt_nxt == 16'd0);
               dut_in <= '0;
               dut_en <= 1'b0;
            end
            default: begin
               dut_in <= '0;
               dut_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accum_stim_checker.sv
// Bench for accum_stim_checker. Two checker instances (small directed
// config, and a longer random-enable config) each drive a behavioural
// accumulator; faults and output glitches are injected into those
// accumulators and every checker output is predicted cycle by cycle from a
// model built straight from the stimulus rules.
module tb_accum_stim_checker;

   logic        clock = 1'b0;
   logic        rst_a = 1'b1;
   logic        rst_b = 1'b1;
   int          fault = 0;
   logic [31:0] g     = 32'h0;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   logic        a_dut_reset, a_en, a_done, a_pass, a_fp;
   logic [31:0] a_in, a_out, a_acc, a_dly;
   logic [15:0] a_cnt, a_first;
   logic        b_dut_reset, b_en, b_done, b_pass, b_fp;
   logic [31:0] b_in, b_out, b_acc;
   logic [15:0] b_cnt, b_first;

   accum_stim_checker #(
      .WIDTH(32), .CYCLES(4), .RESET_CYCLES(3), .SEED(32'h1),
      .IN_MASK(32'h0000_00FF), .EN_RANDOM(0)
   ) u_a (
      .clock(clock), .reset(rst_a), .dut_reset(a_dut_reset), .dut_in(a_in),
      .dut_en(a_en), .dut_out(a_out), .done(a_done), .pass(a_pass),
      .fail_pulse(a_fp), .mismatch_count(a_cnt), .first_fail_idx(a_first)
   );

   accum_stim_checker #(
      .WIDTH(32), .CYCLES(300), .RESET_CYCLES(2), .SEED(32'hACE1_2345),
      .IN_MASK(32'hFFFF_FFFF), .EN_RANDOM(1)
   ) u_b (
      .clock(clock), .reset(rst_b), .dut_reset(b_dut_reset), .dut_in(b_in),
      .dut_en(b_en), .dut_out(b_out), .done(b_done), .pass(b_pass),
      .fail_pulse(b_fp), .mismatch_count(b_cnt), .first_fail_idx(b_first)
   );

   // accumulators under test; a_dly models an extra output register stage
   always_ff @(posedge clock) begin
      if (a_dut_reset) begin
         a_acc <= 32'h0;
         a_dly <= 32'h0;
      end else begin
         if (a_en) a_acc <= a_acc + a_in;
         a_dly <= a_acc;
      end
      if (b_dut_reset) b_acc <= 32'h0;
      else if (b_en)   b_acc <= b_acc + b_in;
   end

   always_comb begin
      case (fault)
         1:       a_out = a_acc & ~32'h1;
         2:       a_out = a_dly;
         default: a_out = a_acc;
      endcase
      b_out = b_acc ^ g;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inst 0/1 selects the checker; flt: 0 none, 1 bit0 stuck low,
   // 2 extra stage (inst 0); gpct: glitch percentage (inst 1);
   // abort_t >= 0: stop at that cycle so the next run applies reset mid-run
   task automatic run(input int inst, input int flt, input int gpct, input int abort_t);
      int          nc, nr, tmax, k;
      logic [31:0] seed, mask, s, sum, fo, ein;
      bit          enr, een, efp;
      logic [31:0] inb[$];
      logic [31:0] sums[$];
      bit          enb[$];
      logic [15:0] ecnt, efirst;
      logic        o_rst, o_en, o_done, o_pass, o_fp;
      logic [31:0] o_in;
      logic [15:0] o_cnt, o_first;

      if (inst == 0) begin
         nc = 4;   nr = 3; seed = 32'h1;         mask = 32'hFF; enr = 1'b0;
      end else begin
         nc = 300; nr = 2; seed = 32'hACE1_2345; mask = '1;     enr = 1'b1;
      end
      s = seed; sum = 32'h0;
      for (int i = 0; i < nc; i++) begin
         inb.push_back(s & mask);
         enb.push_back(enr ? s[31] : 1'b1);
         sums.push_back(sum);              // accumulator value seen during beat i
         if (enb[i]) sum = sum + inb[i];
         s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
      end
      sums.push_back(sum);                 // value checked in DRAIN

      fault = (inst == 0) ? flt : 0;
      g = 32'h0;
      if (inst == 0) rst_a = 1'b1; else rst_b = 1'b1;
      @(negedge clock);
      if (inst == 0) rst_a = 1'b0; else rst_b = 1'b0;

      ecnt = 16'h0; efirst = 16'hFFFF; efp = 1'b0;
      tmax = (abort_t >= 0) ? abort_t : nr + nc + 2;
      for (int t = 0; t <= tmax; t++) begin
         if (t > 0) @(negedge clock);
         if (inst == 0) begin
            o_rst = a_dut_reset; o_in = a_in; o_en = a_en; o_done = a_done;
            o_pass = a_pass; o_fp = a_fp; o_cnt = a_cnt; o_first = a_first;
         end else begin
            o_rst = b_dut_reset; o_in = b_in; o_en = b_en; o_done = b_done;
            o_pass = b_pass; o_fp = b_fp; o_cnt = b_cnt; o_first = b_first;
         end
         k = t - nr;
         ein = 32'h0; een = 1'b0;
         if (t >= nr && t < nr + nc) begin
            ein = inb[k]; een = enb[k];
         end
         chk("dut_reset",      {31'h0, o_rst},  {31'h0, (t < nr)});
         chk("dut_in",         o_in,            ein);
         chk("dut_en",         {31'h0, o_en},   {31'h0, een});
         chk("done",           {31'h0, o_done}, {31'h0, (t > nr + nc)});
         chk("pass",           {31'h0, o_pass}, {31'h0, (t > nr + nc) && (ecnt == 16'h0)});
         chk("fail_pulse",     {31'h0, o_fp},   {31'h0, efp});
         chk("mismatch_count", {16'h0, o_cnt},  {16'h0, ecnt});
         chk("first_fail_idx", {16'h0, o_first},{16'h0, efirst});

         // glitch for the compare at the end of this cycle, and its outcome
         g = 32'h0;
         if (gpct > 0 && $urandom_range(99) < gpct) g = $urandom | 32'h1;
         efp = 1'b0;
         if (t >= nr && t <= nr + nc) begin
            case (flt)
               1:       fo = sums[k] & ~32'h1;
               2:       fo = (k == 0) ? 32'h0 : sums[k-1];
               default: fo = sums[k] ^ g;
            endcase
            if (fo != sums[k]) begin
               efp = 1'b1;
               if (ecnt != 16'hFFFF) ecnt++;
               if (efirst == 16'hFFFF) efirst = 16'(k);
            end
         end
      end
      g = 32'h0;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      run(0, 0, 0, -1);     // clean: 1,3,2,1 -> pass
      run(0, 1, 0, -1);     // bit0 stuck low
      run(0, 2, 0, -1);     // extra output stage
      run(0, 0, 0, 3 + 2);  // reset lands during beat 2
      run(0, 0, 0, -1);     // bit-identical rerun
      run(1, 0, 0, -1);     // random enable, wrapping sums
      run(1, 0, 5, -1);     // random output glitches
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
